// File: rtl/pwm_pkg.sv
// ============================================================================
// pwm_pkg : shared constants and types for the multi-channel PWM generator
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package pwm_pkg;

  // Configuration registers sit directly above the CHANNELS duty registers;
  // these are offsets from CHANNELS, resolved with cfg_addr().
  localparam int ADDR_TOP      = 0;
  localparam int ADDR_PRESC    = 1;
  localparam int ADDR_CTRL     = 2;
  localparam int NUM_CFG_REGS  = 3;

  localparam int CTRL_MODE_BIT = 0;
  localparam int CTRL_POL_LSB  = 1;

  typedef enum logic {
    MODE_EDGE   = 1'b0,
    MODE_CENTER = 1'b1
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  function automatic int cfg_addr(input int channels, input int ofs);
    return channels + ofs;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_timebase.sv
// ============================================================================
// pwm_timebase : prescaler plus edge/center period counter, boundary detect
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [CNT_W-1:0]   top_i,
  input  logic [PRESC_W-1:0] presc_i,
  input  mode_e              mode_i,
  output logic [CNT_W-1:0]   cnt_o,
  output logic               boundary_o
);

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  dir_e               dir_q, dir_d;
  logic               tick;
  logic               at_top;
  logic               at_bottom;
  logic               boundary;

  always_comb begin
    // >= rather than == keeps the counters sane if a commit shrinks TOP/PRESC
    tick      = (presc_q >= presc_i);
    at_top    = (cnt_q >= top_i);
    at_bottom = (cnt_q == '0);
    presc_d   = tick ? '0 : presc_q + PRESC_W'(1);
    cnt_d     = cnt_q;
    dir_d     = dir_q;
    boundary  = 1'b0;

    if (tick) begin
      if (top_i == '0) begin
        cnt_d    = '0;
        dir_d    = DIR_UP;
        boundary = 1'b1;
      end else if (mode_i == MODE_EDGE) begin
        boundary = at_top;
        cnt_d    = at_top ? '0 : cnt_q + CNT_W'(1);
        dir_d    = DIR_UP;
      end else if (dir_q == DIR_UP) begin
        if (at_top) begin
          dir_d = DIR_DOWN;
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        if (at_bottom) begin
          boundary = 1'b1;
          dir_d    = DIR_UP;
          cnt_d    = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
    end

    if (!en) begin
      presc_d  = '0;
      cnt_d    = '0;
      dir_d    = DIR_UP;
      boundary = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      cnt_q   <= '0;
      dir_q   <= DIR_UP;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign boundary_o = boundary;

endmodule

`default_nettype wire

// File: rtl/pwm_multi_channel.sv
// ============================================================================
// pwm_multi_channel : N-channel PWM with shadow/active register file
// Optional: PWM_INVERT_EN adds per-channel output polarity (CTRL[CHANNELS:1])
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module pwm_multi_channel
  import pwm_pkg::*;
#(
  parameter  int CHANNELS = 4,
  parameter  int CNT_W    = 8,
  parameter  int PRESC_W  = 8,
  localparam int AW       = $clog2(CHANNELS + NUM_CFG_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [AW-1:0]       wr_addr,
  input  logic [CNT_W-1:0]    wr_data,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_tick,
  output logic [CNT_W-1:0]    cnt_o
);

`ifdef PWM_INVERT_EN
  localparam int CTRL_W = CHANNELS + 1;
`else
  localparam int CTRL_W = 1;
`endif

  logic [CNT_W-1:0]    duty_sh_q  [CHANNELS];
  logic [CNT_W-1:0]    duty_sh_d  [CHANNELS];
  logic [CNT_W-1:0]    duty_act_q [CHANNELS];
  logic [CNT_W-1:0]    duty_act_d [CHANNELS];
  logic [CNT_W-1:0]    top_sh_q, top_sh_d, top_act_q, top_act_d;
  logic [PRESC_W-1:0]  presc_sh_q, presc_sh_d, presc_act_q, presc_act_d;
  logic [CTRL_W-1:0]   ctrl_sh_q, ctrl_sh_d, ctrl_act_q, ctrl_act_d;
  logic [CHANNELS-1:0] pwm_q, pwm_d;
  logic                period_tick_q;
  logic [CNT_W-1:0]    cnt;
  logic                boundary;
  logic                wr_fire;
  mode_e               mode;

  assign mode = mode_e'(ctrl_act_q[CTRL_MODE_BIT]);

  pwm_timebase #(
    .CNT_W   (CNT_W),
    .PRESC_W (PRESC_W)
  ) u_timebase (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .top_i      (top_act_q),
    .presc_i    (presc_act_q),
    .mode_i     (mode),
    .cnt_o      (cnt),
    .boundary_o (boundary)
  );

  // Holding off writes in the commit cycle keeps shadow->active copies atomic.
  assign wr_ready = ~boundary;

  always_comb begin
    wr_fire    = wr_valid && wr_ready;
    duty_sh_d  = duty_sh_q;
    top_sh_d   = top_sh_q;
    presc_sh_d = presc_sh_q;
    ctrl_sh_d  = ctrl_sh_q;

    if (wr_fire) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr_addr == AW'(i)) duty_sh_d[i] = wr_data;
      end
      if (wr_addr == AW'(cfg_addr(CHANNELS, ADDR_TOP)))   top_sh_d   = wr_data;
      if (wr_addr == AW'(cfg_addr(CHANNELS, ADDR_PRESC))) presc_sh_d = PRESC_W'(wr_data);
      if (wr_addr == AW'(cfg_addr(CHANNELS, ADDR_CTRL)))  ctrl_sh_d  = CTRL_W'(wr_data);
    end

    duty_act_d  = duty_act_q;
    top_act_d   = top_act_q;
    presc_act_d = presc_act_q;
    ctrl_act_d  = ctrl_act_q;

    // While idle, track the next shadow value so a write in the last idle
    // cycle is already live when en rises.
    if (!en || boundary) begin
      duty_act_d  = duty_sh_d;
      top_act_d   = top_sh_d;
      presc_act_d = presc_sh_d;
      ctrl_act_d  = ctrl_sh_d;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic cmp;
    assign cmp = (cnt < duty_act_q[g]);
`ifdef PWM_INVERT_EN
    assign pwm_d[g] = en ? (cmp ^ ctrl_act_q[CTRL_POL_LSB + g])
                         : ctrl_act_q[CTRL_POL_LSB + g];
`else
    assign pwm_d[g] = en & cmp;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      duty_sh_q     <= '{default: '0};
      duty_act_q    <= '{default: '0};
      top_sh_q      <= '1;
      top_act_q     <= '1;
      presc_sh_q    <= '0;
      presc_act_q   <= '0;
      ctrl_sh_q     <= '0;
      ctrl_act_q    <= '0;
      pwm_q         <= '0;
      period_tick_q <= 1'b0;
    end else begin
      duty_sh_q     <= duty_sh_d;
      duty_act_q    <= duty_act_d;
      top_sh_q      <= top_sh_d;
      top_act_q     <= top_act_d;
      presc_sh_q    <= presc_sh_d;
      presc_act_q   <= presc_act_d;
      ctrl_sh_q     <= ctrl_sh_d;
      ctrl_act_q    <= ctrl_act_d;
      pwm_q         <= pwm_d;
      period_tick_q <= boundary;
    end
  end

  assign pwm_out     = pwm_q;
  assign period_tick = period_tick_q;
  assign cnt_o       = cnt;

endmodule

`default_nettype wire

// File: tb/tb_pwm_multi_channel.sv
// ============================================================================
// tb_pwm_multi_channel : scoreboard bench; per-period high counts are queued
// by the stimulus and compared by a monitor at every period_tick.
// ============================================================================
`default_nettype none

module tb_pwm_multi_channel;

  localparam int CH = 4;
  localparam int CW = 8;
  localparam int AW = 3;
  localparam int A_TOP = 4;
  localparam int A_PRESC = 5;
  localparam int A_CTRL = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [AW-1:0] wr_addr = '0;
  logic [CW-1:0] wr_data = '0;
  logic [CH-1:0] pwm_out;
  logic          period_tick;
  logic [CW-1:0] cnt_o;

  pwm_multi_channel #(.CHANNELS(CH), .CNT_W(CW), .PRESC_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .pwm_out     (pwm_out),
    .period_tick (period_tick),
    .cnt_o       (cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int at_tick;
    int len;
    int hi [CH];
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   tick_count = 0;
  int   win_len = 0;
  int   win_hi [CH];

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
    end
  endfunction

  task automatic push_exp(input int at, input int len, input int h0, input int h1,
                          input int h2, input int h3);
    exp_t e;
    e.at_tick = at;
    e.len     = len;
    e.hi[0]   = h0;
    e.hi[1]   = h1;
    e.hi[2]   = h2;
    e.hi[3]   = h3;
    sb_q.push_back(e);
  endtask

  // Monitor: a window is the run of samples ending at (and including) a
  // period_tick; with the one-cycle output lag this is exactly one period.
  always @(negedge clk) begin
    if (rst || !en) begin
      win_len = 0;
      for (int c = 0; c < CH; c++) win_hi[c] = 0;
    end else begin
      win_len++;
      for (int c = 0; c < CH; c++) win_hi[c] += int'(pwm_out[c]);
      if (period_tick) begin
        exp_t e;
        tick_count++;
        while (sb_q.size() > 0 && sb_q[0].at_tick < tick_count) begin
          e = sb_q.pop_front();
          chk("sb_missed_window", tick_count, e.at_tick);
        end
        if (sb_q.size() > 0 && sb_q[0].at_tick == tick_count) begin
          e = sb_q.pop_front();
          chk($sformatf("period_len[t%0d]", e.at_tick), win_len, e.len);
          for (int c = 0; c < CH; c++)
            chk($sformatf("high_cycles[t%0d][ch%0d]", e.at_tick, c), win_hi[c], e.hi[c]);
        end
        win_len = 0;
        for (int c = 0; c < CH; c++) win_hi[c] = 0;
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic wr(input int addr, input int data, output int stalls);
    logic rdy;
    bit   done;
    wr_valid = 1'b1;
    wr_addr  = addr[AW-1:0];
    wr_data  = data[CW-1:0];
    stalls   = 0;
    done     = 1'b0;
    for (int k = 0; k < 8 && !done; k++) begin
      @(negedge clk);
      rdy = wr_ready;
      @(posedge clk);
      #1;
      if (rdy) done = 1'b1;
      else stalls++;
    end
    wr_valid = 1'b0;
    if (!done) chk("write_accept_timeout", 0, 1);
  endtask

  task automatic wr0(input int addr, input int data);
    int s;
    wr(addr, data, s);
  endtask

  task automatic wait_tick(input int target, input int budget);
    for (int k = 0; k < budget && tick_count < target; k++) begin
      @(posedge clk);
      #1;
    end
    chk("wait_tick_reached", tick_count, target);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired @%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int s;

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_pwm_out", int'(pwm_out), 0);
    chk("rst_cnt", int'(cnt_o), 0);
    chk("rst_period_tick", int'(period_tick), 0);
    chk("rst_wr_ready", int'(wr_ready), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // ---------------- edge mode, TOP=9, duties 0/3/9/10 ----------------
    wr0(0, 0);
    wr0(1, 3);
    wr0(2, 9);
    wr0(3, 10);
    wr0(A_TOP, 9);
    wr0(A_PRESC, 0);
    wr0(A_CTRL, 0);
    en = 1'b1;
    t  = tick_count;
    push_exp(t + 2, 10, 0, 3, 9, 10);
    push_exp(t + 3, 10, 0, 3, 9, 10);
    wait_tick(t + 2, 100);

    // mid-period duty change: current period unaffected
    wr(1, 5, s);
    chk("midperiod_write_stalls", s, 0);
    push_exp(t + 4, 10, 0, 5, 9, 10);

    // write presented in the boundary cycle must stall one cycle
    for (int k = 0; k < 40 && cnt_o != 8'd9; k++) begin
      @(posedge clk);
      #1;
    end
    chk("reach_boundary_cnt", int'(cnt_o), 9);
    wr(2, 4, s);
    chk("boundary_write_stalls", s, 1);
    push_exp(t + 5, 10, 0, 5, 4, 10);
    wait_tick(t + 5, 100);

    // ---------------- center mode, TOP=4, PRESC=1 ----------------
    en = 1'b0;
    wr0(A_TOP, 4);
    wr0(A_PRESC, 1);
    wr0(0, 2);
    wr0(1, 0);
    wr0(2, 5);
    wr0(3, 4);
    wr0(A_CTRL, 1);
    en = 1'b1;
    t  = tick_count;
    push_exp(t + 2, 16, 6, 0, 16, 14);
    push_exp(t + 3, 16, 6, 0, 16, 14);
    wait_tick(t + 3, 200);

    // ---------------- en low for 20 clk, reprogram TOP=3 edge ----------------
    en = 1'b0;
    for (int k = 0; k < 20; k++) begin
      wr_valid = (k >= 3 && k <= 5);
      wr_addr  = (k == 3) ? AW'(A_TOP) : (k == 4) ? AW'(A_CTRL) : AW'(A_PRESC);
      wr_data  = (k == 3) ? 8'd3 : 8'd0;
      @(negedge clk);
      if (k >= 1) chk($sformatf("en_low_idle[%0d]", k), int'({pwm_out, cnt_o}), 0);
      if (k >= 3 && k <= 5) chk($sformatf("en_low_wr_ready[%0d]", k), int'(wr_ready), 1);
      @(posedge clk);
      #1;
    end
    wr_valid = 1'b0;
    en = 1'b1;
    t  = tick_count;
    push_exp(t + 2, 4, 2, 0, 4, 4);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("en_rise_cnt[%0d]", k), int'(cnt_o), (k == 5) ? 0 : k - 1);
      chk($sformatf("en_rise_tick[%0d]", k), int'(period_tick), (k == 5) ? 1 : 0);
      @(posedge clk);
      #1;
    end
    wait_tick(t + 2, 50);

    // ---------------- reset mid-period ----------------
    wr0(0, 7);
    wait_tick(tick_count + 2, 50);
    @(posedge clk);
    #1;
    chk("pre_rst_duty7_high", int'(pwm_out[0]), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("post_rst_pwm_out", int'(pwm_out), 0);
    chk("post_rst_cnt", int'(cnt_o), 0);
    chk("post_rst_period_tick", int'(period_tick), 0);
    chk("post_rst_wr_ready", int'(wr_ready), 1);
    t = tick_count;
    wr0(0, 200);
    push_exp(t + 2, 256, 200, 0, 0, 0);
    wait_tick(t + 2, 700);

`ifdef PWM_INVERT_EN
    // ---------------- polarity inversion ----------------
    en = 1'b0;
    wr0(A_TOP, 9);
    wr0(A_PRESC, 0);
    wr0(0, 3);
    wr0(A_CTRL, 2);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("inv_idle_level", int'(pwm_out), 1);
    @(posedge clk);
    #1;
    en = 1'b1;
    t  = tick_count;
    push_exp(t + 2, 10, 7, 0, 0, 0);
    wait_tick(t + 2, 60);
    en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("inv_en_low_held_high", int'(pwm_out[0]), 1);
`endif

    chk("scoreboard_drained", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
